// File: rtl/posit_accumulator_8bit.sv
// rtl/posit_accumulator_8bit.sv - posit8 (es=0) streaming accumulator with combinational posit adder.
// Optional beat counter enabled by macro POSIT_ACC_COUNT_EN (out_count tied to 0 when undefined).

module posit_adder_8bit (
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    output logic [7:0] sum
);

    // Exact fixed-point image of a posit8/es=0 value, LSB weight 2^-12.
    function automatic logic signed [20:0] to_fixed(input logic [7:0] x);
        logic [6:0]  a;
        logic [2:0]  m;
        logic        run;
        logic [5:0]  frac;
        logic [3:0]  sh;
        logic [18:0] mag;
        a   = x[7] ? (~x[6:0] + 7'd1) : x[6:0];
        m   = 3'd0;
        run = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            if (run && (a[i] == a[6])) m = m + 3'd1;
            else                       run = 1'b0;
        end
        frac = a[5:0] << m;
        sh   = a[6] ? ({1'b0, m} + 4'd5) : (4'd6 - {1'b0, m});
        mag  = {12'd0, 1'b1, frac} << sh;
        if (x == 8'h00) return 21'sd0;
        return x[7] ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    endfunction

    logic signed [20:0] fix_s;
    logic [20:0]        abs_s;
    logic [20:0]        norm;
    logic [4:0]         lead;
    logic [31:0]        v;
    logic               inc;
    logic [6:0]         body;
    logic [7:0]         pos;

    always_comb begin
        fix_s = to_fixed(lhs) + to_fixed(rhs);
        abs_s = fix_s[20] ? -fix_s : fix_s;
        lead  = 5'd0;
        for (int i = 0; i < 21; i++) begin
            if (abs_s[i]) lead = 5'(i);
        end
        norm = abs_s << (5'd20 - lead);
        v    = 32'd0;
        inc  = 1'b0;
        // Scale is lead-12; outside [-6,6] the result clamps to maxpos/minpos.
        if (lead >= 5'd19) begin
            body = 7'h7F;
        end else if (lead < 5'd6) begin
            body = 7'h01;
        end else begin
            if (lead >= 5'd12) v = ~(~{1'b0, norm[19:0], 11'd0} >> (lead - 5'd11));
            else               v = {norm, 11'd0} >> (5'd12 - lead);
            inc  = v[24] & ((|v[23:0]) | v[25]);
            body = v[31:25] + {6'd0, inc};
        end
        pos = {1'b0, body};
        if ((lhs == 8'h80) || (rhs == 8'h80)) sum = 8'h80;
        else if (fix_s == 21'sd0)             sum = 8'h00;
        else if (fix_s[20])                   sum = ~pos + 8'd1;
        else                                  sum = pos;
    end

endmodule

module posit_accumulator_8bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t     state_q, state_d;
    logic       run_q, run_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] add_sum;
    logic       beat;

    posit_adder_8bit u_adder (
        .lhs (acc_q),
        .rhs (in_data),
        .sum (add_sum)
    );

    assign in_ready  = run_q && (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_ACC: begin
                if (beat) begin
                    if (in_last) begin
                        out_data_d = add_sum;
                        acc_d      = 8'h00;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d = add_sum;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            run_q      <= 1'b0;
            acc_q      <= 8'h00;
            out_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef POSIT_ACC_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    always_comb begin
        cnt_inc     = (&cnt_q) ? cnt_q : (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        if (beat) begin
            if (in_last) begin
                out_count_d = cnt_inc;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_posit_accumulator_8bit.sv
// tb/tb_posit_accumulator_8bit.sv - scoreboard bench for posit_accumulator_8bit.

module tb_posit_accumulator_8bit;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] beats;
        logic [2:0]  n;
        logic [7:0]  exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b1;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] out_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    vec_t        vecs[12];

    always #5 clk = ~clk;

    posit_accumulator_8bit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        logic [CNT_W-1:0] c;
        c = (n > (2**CNT_W - 1)) ? {CNT_W{1'b1}} : CNT_W'(n);
`ifndef POSIT_ACC_COUNT_EN
        c = '0;
`endif
        return c;
    endfunction

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, out_valid}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks stability while stalled.
    logic        held = 1'b0;
    logic [15:0] prev = 16'h0;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) check("hold_stable", {16'd0, out_data, out_count}, {16'd0, prev});
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h expected none", {out_data, out_count});
                end else begin
                    check("result", {16'd0, out_data, out_count}, {16'd0, exp_q.pop_front()});
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                prev = {out_data, out_count};
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish expected finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{beats: 32'h0000_4040, n: 3'd2, exp: 8'h60};
        vecs[1]  = '{beats: 32'h0000_C040, n: 3'd2, exp: 8'h00};
        vecs[2]  = '{beats: 32'h0000_0020, n: 3'd1, exp: 8'h20};
        vecs[3]  = '{beats: 32'h0040_8040, n: 3'd3, exp: 8'h80};
        vecs[4]  = '{beats: 32'h0000_0040, n: 3'd3, exp: 8'h40};
        vecs[5]  = '{beats: 32'h0000_2040, n: 3'd2, exp: 8'h50};
        vecs[6]  = '{beats: 32'h0000_4060, n: 3'd2, exp: 8'h68};
        vecs[7]  = '{beats: 32'h0000_E0C0, n: 3'd2, exp: 8'hB0};
        vecs[8]  = '{beats: 32'h0000_407F, n: 3'd2, exp: 8'h7F};
        vecs[9]  = '{beats: 32'h0000_0141, n: 3'd2, exp: 8'h42};
        vecs[10] = '{beats: 32'h0000_0140, n: 3'd2, exp: 8'h40};
        vecs[11] = '{beats: 32'h0000_4080, n: 3'd2, exp: 8'h80};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_count", {24'd0, out_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        foreach (vecs[k]) begin
            for (int i = 0; i < int'(vecs[k].n); i++) begin
                if (i == int'(vecs[k].n) - 1)
                    exp_q.push_back({vecs[k].exp, exp_cnt(int'(vecs[k].n))});
                send(vecs[k].beats[8*i +: 8], i == int'(vecs[k].n) - 1);
            end
            check("latency_valid", {31'd0, out_valid}, 32'd1);
            check("hold_not_ready", {31'd0, in_ready}, 32'd0);
            wait_idle();
        end

        // Stalled consumer, then a beat presented alongside the release.
        out_ready = 1'b0;
        exp_q.push_back({8'h20, exp_cnt(1)});
        send(8'h20, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("stall_not_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h40;
        in_last   = 1'b1;
        exp_q.push_back({8'h40, exp_cnt(1)});
        @(negedge clk);
        check("no_accept_on_exit", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("exit_valid_low", {31'd0, out_valid}, 32'd0);
        check("ready_after_exit", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("accept_one_after", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();

        // Reset mid-sum discards the partial sum.
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        exp_q.push_back({8'h40, exp_cnt(1)});
        send(8'h40, 1'b1);
        check("midrst_latency", {31'd0, out_valid}, 32'd1);
        wait_idle();

        // Reset while holding a result drops it.
        out_ready = 1'b0;
        send(8'h60, 1'b1);
        check("hold_before_rst", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("holdrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        exp_q.push_back({8'h20, exp_cnt(1)});
        send(8'h20, 1'b1);
        wait_idle();

        // Counter saturation: 2^CNT_W+4 zero beats in one sum.
        for (int i = 0; i < (2**CNT_W) + 4; i++) begin
            if (i == (2**CNT_W) + 3) exp_q.push_back({8'h00, exp_cnt((2**CNT_W) + 4)});
            send(8'h00, i == (2**CNT_W) + 3);
        end
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/posit_accumulator_8bit.md
POSIT_ACCUMULATOR_8BIT -- requirements
Module: posit_accumulator_8bit

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the beat counter and of out_count.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: in_data/in_last valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-006 SHALL have port in_data, input, 8: posit8 operand.
REQ-007 SHALL have port in_last, input, 1: final beat of the current sum.
REQ-008 SHALL have port out_valid, output, 1: out_data/out_count hold a completed sum.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port out_data, output, 8: posit8 accumulated sum.
REQ-011 SHALL have port out_count, output, CNT_W: number of beats in the sum.

Function
REQ-012 SHALL contain one posit_adder_8bit instance, with lhs = acc register and rhs = in_data; the adder is combinational, so a beat is summed in its acceptance cycle.
REQ-013 SHALL implement two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL define a beat as accepted when in_valid && in_ready at a rising edge.
REQ-015 In ACC, on an accepted beat with in_last=0: acc <= adder result; cnt <= cnt+1, saturating at 2^CNT_W-1.
REQ-016 In ACC, on an accepted beat with in_last=1: out_data <= adder result; out_count <= cnt+1 (saturating); acc <= 8'h00; cnt <= 0; state -> HOLD.
REQ-017 Latency: out_valid SHALL assert in the cycle immediately after the edge that accepts the last beat.
REQ-018 In HOLD, out_data and out_count SHALL remain stable until out_valid && out_ready; that edge returns the state to ACC.
REQ-019 No input beat SHALL be accepted in the cycle in which HOLD is exited; the next beat is accepted one cycle later at the earliest.
REQ-020 In ACC with in_valid=0, acc, cnt and the state SHALL hold.
REQ-021 A single-beat sum (in_last on the first beat) SHALL produce out_data = 0 + in_data = in_data and out_count = 1.
REQ-022 Infinity (8'h80) SHALL propagate through the adder: once accumulated, every later result of the same sum is 8'h80.
REQ-023 A zero operand (8'h00) SHALL count as a beat and leave acc unchanged.

Reset
REQ-024 While rst_n=0, the block SHALL set state=ACC, acc=8'h00, cnt=0, out_data=8'h00, out_count=0, out_valid=0 and in_ready=0.
REQ-025 in_ready SHALL go high in the first cycle after rst_n deasserts.
REQ-026 Reset asserted mid-sum or in HOLD SHALL discard the partial sum and any pending result, with no output emitted.

Configuration
REQ-027 Macro POSIT_ACC_COUNT_EN SHALL control the beat counter.
- Defined: cnt and out_count behave per REQ-015/016.
- Undefined: the counter is not built, out_count is tied to 0, and all other behaviour is identical.

Verification
REQ-028 Beats 8'h40, 8'h40(last) -> one cycle later: out_valid=1, out_data=8'h60, out_count=2.
REQ-029 Beats 8'h40, 8'hC0(last) -> out_data=8'h00, out_count=2; the next sum starts from acc=8'h00.
REQ-030 Beats 8'h40, 8'h80, 8'h40(last) -> out_data=8'h80, out_count=3.
REQ-031 Single beat 8'h20(last) with out_ready held 0 for 5 cycles -> out_data=8'h20 stable; in_ready=0 throughout; the beat after the release is accepted one cycle after the handshake.
REQ-032 Assert rst_n=0 after 2 of 3 beats -> out_valid never asserts; the next sequence 8'h40(last) yields 8'h40, count=1.
REQ-033 2^CNT_W+3 beats of 8'h00 then last -> out_count saturates at 2^CNT_W-1; with POSIT_ACC_COUNT_EN undefined, out_count=0 in all cases.
